// File: rtl/latch_vec_event_capture.sv
// rtl/latch_vec_event_capture.sv - synchronise an async latch vector, filter for stability, queue change events
module latch_vec_event_capture #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 3,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [WIDTH-1:0]              i_a,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [WIDTH-1:0]              o_data,
  output logic [WIDTH-1:0]              o_mask,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  // A single-sample window still needs a one-bit counter to keep the types legal.
  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  logic [WIDTH-1:0]   sync1_q, sync1_d;
  logic [WIDTH-1:0]   sync2_q, sync2_d;
  logic [WIDTH-1:0]   cand_q, cand_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   committed_q, committed_d;
  logic [2*WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [2*WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               overflow_q, overflow_d;

  logic commit;
  logic pop;
  logic full;
  logic wr_en;

  // Synchroniser and stability filter: commit once cand has been seen STABLE_CYCLES times in a row.
  always_comb begin
    sync1_d     = i_a;
    sync2_d     = sync1_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    committed_d = committed_q;
    commit      = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CW'(1);
      end
      // Committed value moves even if the event is dropped, so later masks stay relative to it.
      if ((cnt_q == CNT_MAX) && (cand_q != committed_q)) begin
        commit      = 1'b1;
        committed_d = cand_q;
      end
    end
  end

  // Event FIFO: a push into a full queue is only accepted when the head leaves on the same edge.
  always_comb begin
    pop        = o_valid && i_ready;
    full       = (level_q == LVL_FULL);
    wr_en      = commit && (!full || pop);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = {cand_q, cand_q ^ committed_q};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    level_d = level_q + LW'(wr_en) - LW'(pop);
    if (commit && full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      cand_q      <= '0;
      cnt_q       <= '0;
      committed_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      committed_q <= committed_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
    end
  end

  // Head entry is presented only while the queue is non-empty; outputs read zero otherwise.
  always_comb begin
    o_valid    = (level_q != '0);
    o_data     = o_valid ? mem_q[rd_ptr_q][2*WIDTH-1:WIDTH] : '0;
    o_mask     = o_valid ? mem_q[rd_ptr_q][WIDTH-1:0] : '0;
    o_level    = level_q;
    o_overflow = overflow_q;
  end

endmodule
